// File: rtl/dmem_mmio_responder.sv
// Single-cycle data-memory responder: byte-lane RAM plus a small MMIO block
// (free-running cycle counter, TX byte FIFO with status, compare timer IRQ).
module dmem_mmio_responder #(
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwe,
   output logic [31:0] drdata,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        timer_irq
);

   localparam int RAW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [29:0] A_CYCLE  = 30'h0000_4000;
   localparam logic [29:0] A_TXDATA = 30'h0000_4001;
   localparam logic [29:0] A_STATUS = 30'h0000_4002;
   localparam logic [29:0] A_TCMP   = 30'h0000_4003;
   localparam logic [PW:0] C_DEPTH  = (PW + 1)'(FIFO_DEPTH);

   logic [31:0]    r_ram [RAM_WORDS];
   logic [7:0]     r_fifo [FIFO_DEPTH];
   logic [31:0]    r_cycle;
   logic [31:0]    r_tcmp;
   logic           r_irq;
   logic [PW-1:0]  r_wptr;
   logic [PW-1:0]  r_rptr;
   logic [PW:0]    r_count;
   logic           r_ovf;

   logic [29:0]    w_word;
   logic           w_ram_hit;
   logic [RAW-1:0] w_ram_idx;
   logic           w_wr;
   logic           w_push;
   logic           w_pop;
   logic           w_full;
   logic           w_empty;
   logic           w_push_ok;
   logic           w_ovf_set;
   logic           w_stat_clr;
   logic           w_tcmp_wr;
   logic [3:0]     w_count4;
   logic           w_unused_lsb;

   // Byte offset within a word has no meaning on this port.
   assign w_unused_lsb = ^daddr[1:0];

   assign w_word     = daddr[31:2];
   assign w_ram_hit  = (w_word < 30'(RAM_WORDS));
   assign w_ram_idx  = daddr[RAW+1:2];
   assign w_wr       = |dwe;
   assign w_full     = (r_count == C_DEPTH);
   assign w_empty    = (r_count == '0);
   assign w_pop      = !w_empty && tx_ready;
   assign w_push     = (w_word == A_TXDATA) && dwe[0];
   assign w_push_ok  = w_push && (!w_full || w_pop);
   assign w_ovf_set  = w_push && w_full && !w_pop;
   assign w_stat_clr = (w_word == A_STATUS) && w_wr;
   assign w_tcmp_wr  = (w_word == A_TCMP) && w_wr;
   assign w_count4   = 4'(r_count);

   assign tx_valid  = !w_empty;
   assign tx_data   = w_empty ? 8'h00 : r_fifo[r_rptr];
   assign timer_irq = r_irq;

   // RAM and FIFO storage carry no reset; validity comes from the pointers.
   always_ff @(posedge clk) begin
      if (w_ram_hit) begin
         for (int i = 0; i < 4; i++) begin
            if (dwe[i]) r_ram[w_ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
         end
      end
      if (w_push_ok) r_fifo[r_wptr] <= dwdata[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle <= '0;
         r_tcmp  <= '0;
         r_irq   <= 1'b0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_tcmp_wr) begin
            for (int i = 0; i < 4; i++) begin
               if (dwe[i]) r_tcmp[8*i +: 8] <= dwdata[8*i +: 8];
            end
         end
         // A compare write clears the flag even on the matching cycle.
         if (w_tcmp_wr) r_irq <= 1'b0;
         else if ((r_tcmp != '0) && (r_cycle == r_tcmp)) r_irq <= 1'b1;
         if (w_push_ok) r_wptr <= r_wptr + PW'(1);
         if (w_pop)     r_rptr <= r_rptr + PW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + (PW + 1)'(1);
            2'b01:   r_count <= r_count - (PW + 1)'(1);
            default: r_count <= r_count;
         endcase
         // Overflow set takes priority over a STATUS clear.
         if (w_ovf_set)       r_ovf <= 1'b1;
         else if (w_stat_clr) r_ovf <= 1'b0;
      end
   end

   always_comb begin
      drdata = 32'h0;
      if (w_ram_hit) begin
         drdata = r_ram[w_ram_idx];
      end else begin
         case (w_word)
            A_CYCLE:  drdata = r_cycle;
            A_STATUS: drdata = {24'h0, w_count4, 1'b0, r_ovf, w_full, w_empty};
            A_TCMP:   drdata = r_tcmp;
            default:  drdata = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM lanes, TX FIFO, timer, reset, unmapped.
module tb_dmem_mmio_responder;

   localparam logic [31:0] A_CYCLE  = 32'h0001_0000;
   localparam logic [31:0] A_TXDATA = 32'h0001_0004;
   localparam logic [31:0] A_STATUS = 32'h0001_0008;
   localparam logic [31:0] A_TCMP   = 32'h0001_000C;

   logic        clk;
   logic        reset;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  dwe;
   logic [31:0] drdata;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        timer_irq;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] v;
   logic        found;

   dmem_mmio_responder #(.RAM_WORDS(1024), .FIFO_DEPTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .daddr     (daddr),
      .dwdata    (dwdata),
      .dwe       (dwe),
      .drdata    (drdata),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .timer_irq (timer_irq)
   );

   // clock/reset
   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      daddr = a;
      dwe   = 4'h0;
      #1;
      d = drdata;
   endtask

   task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(tag, d, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      @(negedge clk);
      daddr  = a;
      dwdata = d;
      dwe    = we;
      @(posedge clk);
      #1;
      dwe = 4'h0;
   endtask

   task automatic push(input logic [7:0] b);
      wr(A_TXDATA, {24'h0, b}, 4'h1);
      if (exp_q.size() < 8) exp_q.push_back(b);
   endtask

   task automatic drain(input int n);
      logic [7:0] e;
      @(negedge clk);
      tx_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         #1;
         e = exp_q.pop_front();
         chk("drain_valid", {31'h0, tx_valid}, 32'h1);
         chk("drain_data", {24'h0, tx_data}, {24'h0, e});
         @(negedge clk);
      end
      tx_ready = 1'b0;
   endtask

   initial begin
      reset    = 1'b0;
      daddr    = 32'h0;
      dwdata   = 32'h0;
      dwe      = 4'h0;
      tx_ready = 1'b0;
      #5 reset = 1'b1;
      #5;
      chk_rd("rst_status", A_STATUS, 32'h0000_0001);
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
      chk("rst_irq", {31'h0, timer_irq}, 32'h0);
      chk_rd("rst_cycle", A_CYCLE, 32'h0);
      chk_rd("rst_tcmp", A_TCMP, 32'h0);
      @(posedge clk);
      #1;
      chk_rd("rst_cycle_held", A_CYCLE, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // RAM byte lanes
      wr(32'h10, 32'hAABB_CCDD, 4'hF);
      wr(32'h10, 32'h0000_0011, 4'h1);
      chk_rd("ram_lane", 32'h10, 32'hAABB_CC11);
      chk_rd("ram_lsb_ignored", 32'h13, 32'hAABB_CC11);
      wr(32'h20, 32'hFFFF_FFFF, 4'hF);
      wr(32'h22, 32'h0000_0000, 4'b0110);
      chk_rd("ram_mid_lanes", 32'h20, 32'hFF00_00FF);
      chk_rd("txdata_reads_zero", A_TXDATA, 32'h0);

      // first push: no bypass
      @(negedge clk);
      daddr  = A_TXDATA;
      dwdata = 32'h41;
      dwe    = 4'h1;
      #1;
      chk("no_bypass_pre", {31'h0, tx_valid}, 32'h0);
      @(posedge clk);
      #1;
      dwe = 4'h0;
      exp_q.push_back(8'h41);
      chk("push_valid_post", {31'h0, tx_valid}, 32'h1);
      chk("push_head", {24'h0, tx_data}, 32'h41);
      wr(A_TXDATA, 32'h99, 4'h2);
      chk_rd("no_push_without_lane0", A_STATUS, 32'h0000_0010);

      // fill, overflow, clear, drain
      for (int b = 8'h42; b <= 8'h48; b++) push(8'(b));
      chk_rd("fill_status", A_STATUS, 32'h0000_0082);
      push(8'h49);
      chk_rd("overflow_status", A_STATUS, 32'h0000_0086);
      chk("head_held_full", {24'h0, tx_data}, 32'h41);
      wr(A_STATUS, 32'h0, 4'hF);
      chk_rd("ovf_cleared", A_STATUS, 32'h0000_0082);
      drain(8);
      chk_rd("drained_status", A_STATUS, 32'h0000_0001);
      chk("drained_tx_data", {24'h0, tx_data}, 32'h0);

      // full push with simultaneous pop
      for (int b = 8'h50; b <= 8'h57; b++) push(8'(b));
      chk_rd("full2_status", A_STATUS, 32'h0000_0082);
      @(negedge clk);
      tx_ready = 1'b1;
      daddr    = A_TXDATA;
      dwdata   = 32'h5A;
      dwe      = 4'h1;
      #1;
      chk("popped_head", {24'h0, tx_data}, 32'h50);
      void'(exp_q.pop_front());
      exp_q.push_back(8'h5A);
      @(posedge clk);
      #1;
      dwe      = 4'h0;
      tx_ready = 1'b0;
      chk_rd("push_pop_full_status", A_STATUS, 32'h0000_0082);
      drain(8);
      chk_rd("drained2_status", A_STATUS, 32'h0000_0001);

      // async reset mid-drain
      for (int b = 8'h60; b <= 8'h64; b++) push(8'(b));
      chk_rd("count5_status", A_STATUS, 32'h0000_0050);
      @(negedge clk);
      #10 reset = 1'b1;
      #1;
      chk("async_rst_valid", {31'h0, tx_valid}, 32'h0);
      chk("async_rst_data", {24'h0, tx_data}, 32'h0);
      chk_rd("async_rst_status", A_STATUS, 32'h0000_0001);
      daddr    = A_TXDATA;
      dwdata   = 32'h77;
      dwe      = 4'h1;
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      dwe      = 4'h0;
      tx_ready = 1'b0;
      chk_rd("rst_discards_push", A_STATUS, 32'h0000_0001);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      chk_rd("ram_survives_reset", 32'h10, 32'hAABB_CC11);

      // unmapped
      wr(32'h0002_0000, 32'h1234_5678, 4'hF);
      chk_rd("unmapped_read", 32'h0002_0000, 32'h0);
      chk_rd("unmapped_status", A_STATUS, 32'h0000_0001);
      chk_rd("unmapped_tcmp", A_TCMP, 32'h0);
      chk_rd("unmapped_ram", 32'h10, 32'hAABB_CC11);
      wr(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
      chk_rd("past_ram_end", 32'h0000_1000, 32'h0);
      chk_rd("mmio_gap", 32'h0001_0010, 32'h0);

      // timer compare
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wr(A_TCMP, 32'd20, 4'hF);
      chk_rd("tcmp_readback", A_TCMP, 32'd20);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         rd(A_CYCLE, v);
         if (v == 32'd20) begin
            found = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("timer_cycle_reached", {31'h0, found}, 32'h1);
      chk("irq_before_match", {31'h0, timer_irq}, 32'h0);
      @(posedge clk);
      #1;
      chk("irq_at_match", {31'h0, timer_irq}, 32'h1);
      chk_rd("cycle_after_match", A_CYCLE, 32'd21);
      repeat (5) @(posedge clk);
      #1;
      chk("irq_sticky", {31'h0, timer_irq}, 32'h1);
      wr(A_TCMP, 32'h1234_5678, 4'hF);
      chk("irq_cleared", {31'h0, timer_irq}, 32'h0);
      wr(A_TCMP, 32'h0000_AB00, 4'b0010);
      chk_rd("tcmp_lane", A_TCMP, 32'h1234_AB78);

      // cycle wrap
      @(negedge clk);
      force dut.r_cycle = 32'hFFFF_FFFE;
      #1;
      release dut.r_cycle;
      chk_rd("cycle_preload", A_CYCLE, 32'hFFFF_FFFE);
      @(posedge clk);
      #1;
      chk_rd("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      chk_rd("cycle_wrap", A_CYCLE, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_mmio_responder.md
DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

Interface
REQ-001 SHALL provide parameter RAM_WORDS, default 1024, number of 32-bit RAM words; power of two, at most 1024.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8, number of TX FIFO entries; power of two, 2..8.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 daddr  input  32  byte address from the CPU data port.
REQ-006 dwdata  input  32  write data from the CPU.
REQ-007 dwe  input  4  byte write enables; dwe[i] covers dwdata[8i+7:8i]; 0 means read.
REQ-008 drdata  output  32  read data returned to the CPU.
REQ-009 tx_valid  output  1  TX FIFO head valid.
REQ-010 tx_data  output  8  TX FIFO head byte.
REQ-011 tx_ready  input  1  downstream accepts the head byte.
REQ-012 timer_irq  output  1  sticky timer-match flag.

Function
REQ-013 drdata SHALL be combinational from daddr and current state (zero-wait read); a read never alters state.
REQ-014 Decode SHALL use daddr[31:2]; daddr[1:0] are ignored.
REQ-015 RAM region is 0x0000_0000 to 4*RAM_WORDS-1; a read returns the word; on a write, each byte with dwe[i]=1 updates at posedge and other bytes are kept.
REQ-016 CYCLE is at 0x0001_0000, read-only; it is a 32-bit counter that increments every cycle and wraps 0xFFFF_FFFF to 0.
REQ-017 TXDATA is at 0x0001_0004; a write with dwe[0]=1 pushes dwdata[7:0]; a read returns 0.
REQ-018 STATUS is at 0x0001_0008; read value = {24'b0, count[3:0], 1'b0, overflow, full, empty}; any write with dwe!=0 clears overflow.
REQ-019 TIMER_CMP is at 0x0001_000C, read/write, with byte-lane writes as REQ-015.
REQ-020 Unmapped addresses SHALL read 0 and ignore writes.
REQ-021 The FIFO SHALL use circular read and write pointers that wrap at FIFO_DEPTH, plus a count of 0..FIFO_DEPTH; full = (count==FIFO_DEPTH); empty = (count==0).
REQ-022 tx_valid = !empty; tx_data = the head entry; a pop occurs at the posedge where tx_valid && tx_ready.
REQ-023 A push when not full SHALL be accepted.
REQ-024 A push when full without a same-cycle pop SHALL be dropped and SHALL set overflow, leaving the FIFO unchanged.
REQ-025 A push when full with a same-cycle pop SHALL be accepted; count is unchanged.
REQ-026 There is no bypass: a push into an empty FIFO raises tx_valid the following cycle.
REQ-027 If an overflow event coincides with a STATUS clear write, overflow SHALL be set (set wins).
REQ-028 timer_irq SHALL set at the posedge where TIMER_CMP!=0 and CYCLE==TIMER_CMP, and hold until cleared.
REQ-029 Any write to TIMER_CMP SHALL clear timer_irq; if set and clear coincide, clear wins.
REQ-030 tx_data SHALL be held stable while tx_valid=1 and tx_ready=0.

Reset
REQ-031 On reset assertion, immediately and independent of clk: CYCLE=0, TIMER_CMP=0, timer_irq=0, pointers=0, count=0, overflow=0, tx_valid=0.
REQ-032 RAM contents SHALL NOT be affected by reset.
REQ-033 tx_data SHALL be 0 while empty after reset.
REQ-034 drdata follows REQ-013 during reset; for example, reading STATUS returns 0x0000_0001.
REQ-035 Reset asserted mid-operation SHALL discard FIFO contents and any pending push or pop.

Verification
REQ-036 Byte-lane RAM: write 0xAABBCCDD to 0x10 with dwe=4'hF, then write 0x00000011 with dwe=4'h1 -> read 0x10 returns 0xAABBCC11.
REQ-037 FIFO fill and overflow, tx_ready=0: push 0x41..0x48 -> STATUS=0x82; push 0x49 -> STATUS=0x86; write STATUS -> 0x82; raise tx_ready -> bytes 0x41..0x48 appear in order, then STATUS=0x01.
REQ-038 Full push with pop: with the FIFO full and tx_ready=1, push 0x5A in the same cycle as a pop -> count stays 8, overflow stays 0, and 0x5A drains last.
REQ-039 Timer: after reset, write TIMER_CMP=20 -> timer_irq rises at the posedge where CYCLE==20, holds, and clears on the next TIMER_CMP write.
REQ-040 Async reset mid-drain: assert reset between edges with count=5 -> tx_valid=0 and STATUS reads 0x01 before the next clk edge; a RAM word written earlier is still readable after reset.
REQ-041 Unmapped and wrap: write 0x12345678 to 0x0002_0000 -> it reads 0 and no state changes; preload CYCLE near 0xFFFF_FFFF (force) -> it reads 0 one cycle after 0xFFFF_FFFF.
